// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - sweeps all rows of an N-variable truth table, one per clock
// Presents each row with its function value and a running count of true rows.
module truth_table_sweeper #(
  parameter int N    = 2,
  parameter int ROWS = 2**N
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic            mode,
  input  logic [ROWS-1:0] tt,
  input  logic            hold,
  output logic            busy,
  output logic            valid,
  output logic [N-1:0]    vars,
  output logic            s,
  output logic [N:0]      ones,
  output logic            done
);

  typedef enum logic [1:0] {IDLE, SWEEP, FINISH} state_t;

  state_t          state;
  logic [ROWS-1:0] tt_q;
  logic            mode_q;
  logic [N-1:0]    nxt;
  logic            f_nxt;
  logic            f_first;

  assign nxt     = vars + N'(1);
  // A set mask bit marks a 0 row in maxterm mode, hence the XOR with mode.
  assign f_nxt   = tt_q[nxt] ^ mode_q;
  assign f_first = tt[0] ^ mode;

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      tt_q   <= '0;
      mode_q <= 1'b0;
      busy   <= 1'b0;
      valid  <= 1'b0;
      vars   <= '0;
      s      <= 1'b0;
      ones   <= '0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state  <= SWEEP;
            tt_q   <= tt;
            mode_q <= mode;
            busy   <= 1'b1;
            valid  <= 1'b1;
            vars   <= '0;
            s      <= f_first;
            ones   <= (N+1)'(f_first);
          end
        end
        SWEEP: begin
          if (!hold) begin
            if (vars == N'(ROWS-1)) begin
              state <= FINISH;
              valid <= 1'b0;
              s     <= 1'b0;
              done  <= 1'b1;
            end else begin
              vars <= nxt;
              s    <= f_nxt;
              ones <= ones + (N+1)'(f_nxt);
            end
          end
        end
        FINISH: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb/tb_truth_table_sweeper.sv - bench for truth_table_sweeper (N=2 and N=3 instances)
module tb_truth_table_sweeper;

  logic       clock = 1'b0;
  logic       reset = 1'b1;

  logic       start2 = 1'b0, mode2 = 1'b0, hold2 = 1'b0;
  logic [3:0] tt2 = '0;
  logic       busy2, valid2, s2, done2;
  logic [1:0] vars2;
  logic [2:0] ones2;

  logic       start3 = 1'b0, mode3 = 1'b0, hold3 = 1'b0;
  logic [7:0] tt3 = '0;
  logic       busy3, valid3, s3, done3;
  logic [2:0] vars3;
  logic [3:0] ones3;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  truth_table_sweeper #(.N(2)) dut2 (
    .clock(clock), .reset(reset), .start(start2), .mode(mode2), .tt(tt2), .hold(hold2),
    .busy(busy2), .valid(valid2), .vars(vars2), .s(s2), .ones(ones2), .done(done2)
  );

  truth_table_sweeper #(.N(3)) dut3 (
    .clock(clock), .reset(reset), .start(start3), .mode(mode3), .tt(tt3), .hold(hold3),
    .busy(busy3), .valid(valid3), .vars(vars3), .s(s3), .ones(ones3), .done(done3)
  );

  typedef struct {
    bit       m;
    bit [3:0] t;
    int       hold_at;
    int       hold_len;
    int       exp_ones;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Function value from the Boolean rule: minterm mask gives T[i], maxterm mask gives ~T[i].
  function automatic bit fval(input bit m, input bit [7:0] t, input int i);
    return m ? !t[i] : t[i];
  endfunction

  task automatic run_sweep(input string tag, input bit m, input bit [3:0] t,
                           input int hold_at, input int hold_len, input int exp_total);
    int cnt;
    cnt = 0;
    @(negedge clock);
    start2 = 1'b1; mode2 = m; tt2 = t;
    @(posedge clock); #1;
    start2 = 1'b0; mode2 = ~m; tt2 = ~t;
    for (int r = 0; r < 4; r++) begin
      if (fval(m, {4'b0, t}, r)) cnt++;
      check({tag, "_valid"}, valid2, 1);
      check({tag, "_vars"}, vars2, r);
      check({tag, "_s"}, s2, fval(m, {4'b0, t}, r));
      check({tag, "_ones"}, ones2, cnt);
      if (r == hold_at) begin
        hold2 = 1'b1;
        for (int h = 0; h < hold_len; h++) begin
          @(posedge clock); #1;
          check({tag, "_hold_vars"}, vars2, r);
          check({tag, "_hold_s"}, s2, fval(m, {4'b0, t}, r));
          check({tag, "_hold_ones"}, ones2, cnt);
          check({tag, "_hold_valid"}, valid2, 1);
        end
        hold2 = 1'b0;
      end
      @(posedge clock); #1;
    end
    check({tag, "_done"}, done2, 1);
    check({tag, "_done_valid"}, valid2, 0);
    check({tag, "_done_busy"}, busy2, 1);
    check({tag, "_total"}, ones2, exp_total);
    check({tag, "_done_vars"}, vars2, 3);
    @(posedge clock); #1;
    check({tag, "_idle_done"}, done2, 0);
    check({tag, "_idle_busy"}, busy2, 0);
    check({tag, "_idle_ones"}, ones2, exp_total);
  endtask

  initial begin
    vec_t vecs[$];
    int   cyc, rows, tot;
    bit   m;
    bit [3:0] t;

    vecs.push_back('{1'b0, 4'b0001, -1, 0, 1});
    vecs.push_back('{1'b1, 4'b0001, -1, 0, 3});
    vecs.push_back('{1'b0, 4'b1111, -1, 0, 4});
    vecs.push_back('{1'b0, 4'b0000, -1, 0, 0});
    vecs.push_back('{1'b0, 4'b0110,  1, 3, 2});
    vecs.push_back('{1'b1, 4'b1111,  2, 1, 0});
    vecs.push_back('{1'b1, 4'b0000,  3, 2, 4});

    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    check("rst_busy", busy2, 0);
    check("rst_valid", valid2, 0);
    check("rst_vars", vars2, 0);
    check("rst_s", s2, 0);
    check("rst_ones", ones2, 0);
    check("rst_done", done2, 0);
    check("rst3_ones", ones3, 0);

    foreach (vecs[i])
      run_sweep($sformatf("vec%0d", i), vecs[i].m, vecs[i].t,
                vecs[i].hold_at, vecs[i].hold_len, vecs[i].exp_ones);

    for (int k = 0; k < 16; k++) begin
      m = 1'($urandom_range(0, 1));
      t = 4'($urandom_range(0, 15));
      tot = m ? 4 - $countones(t) : $countones(t);
      run_sweep($sformatf("rnd%0d", k), m, t, int'($urandom_range(0, 4)) - 1,
                int'($urandom_range(1, 4)), tot);
    end

    // start with a different table during SWEEP and DONE must be ignored
    @(negedge clock);
    start2 = 1'b1; mode2 = 1'b0; tt2 = 4'b0110;
    @(posedge clock); #1;
    tt2 = 4'b1111; mode2 = 1'b1;
    for (int r = 0; r < 4; r++) begin
      check("ign_vars", vars2, r);
      check("ign_s", s2, fval(1'b0, 8'b0110, r));
      @(posedge clock); #1;
    end
    check("ign_done", done2, 1);
    check("ign_total", ones2, 2);
    @(posedge clock); #1;
    start2 = 1'b0;
    check("ign_idle_busy", busy2, 0);
    @(posedge clock); #1;
    check("ign_no_restart", busy2, 0);
    check("ign_no_valid", valid2, 0);
    check("ign_keep_ones", ones2, 2);

    // reset mid-sweep while vars=10
    @(negedge clock);
    start2 = 1'b1; mode2 = 1'b0; tt2 = 4'b0110;
    @(posedge clock); #1;
    start2 = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("mid_vars", vars2, 2);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("mid_rst_busy", busy2, 0);
    check("mid_rst_valid", valid2, 0);
    check("mid_rst_vars", vars2, 0);
    check("mid_rst_s", s2, 0);
    check("mid_rst_ones", ones2, 0);
    check("mid_rst_done", done2, 0);
    @(posedge clock); #1;
    check("mid_rst_no_done", done2, 0);
    check("mid_rst_idle", busy2, 0);
    run_sweep("post_rst", 1'b0, 4'b1010, -1, 0, 2);

    // N=3 sweep: rows and done latency
    @(negedge clock);
    start3 = 1'b1; mode3 = 1'b0; tt3 = 8'b1000_0001;
    cyc = 0; rows = 0;
    while (cyc < 20) begin
      @(posedge clock); #1;
      start3 = 1'b0;
      cyc++;
      if (valid3) begin
        check("n3_vars", vars3, rows);
        check("n3_s", s3, (rows == 0 || rows == 7) ? 1 : 0);
        rows++;
      end
      if (done3) break;
    end
    check("n3_done_cycle", cyc, 9);
    check("n3_rows", rows, 8);
    check("n3_ones", ones3, 2);
    check("n3_done_busy", busy3, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
